// File: rtl/sonar_varredura_ctrl.sv
// Sweep scheduler: ping-pong servo positions, settle, measure (with timeout), hand result to TX.
// Moore FSM; every pulse output decodes from registered state only.
module sonar_varredura_ctrl #(
  parameter int N_POS          = 8,
  parameter int W_POS          = 3,
  parameter int SETTLE_CYCLES  = 50000000,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             medida_pronto,
  input  logic             tx_pronto,
  output logic [W_POS-1:0] posicao,
  output logic             move_servo,
  output logic             inicio_medir,
  output logic             inicia_tx,
  output logic             fim_varredura,
  output logic             erro_timeout,
  output logic [3:0]       db_estado
);

  localparam int MAX_CYC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]    SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [W_POS-1:0] POS_LAST     = W_POS'(N_POS - 1);

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    POSICIONA     = 4'd2,
    ESPERA_SERVO  = 4'd3,
    DISPARA       = 4'd4,
    ESPERA_MEDIDA = 4'd5,
    TRANSMITE     = 4'd6,
    ESPERA_TX     = 4'd7,
    PROXIMA       = 4'd8
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [W_POS-1:0] posicao_q, posicao_d;
  logic             subindo_q, subindo_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             erro_q, erro_d;
  logic             primeira_q, primeira_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIAL;
      posicao_q  <= '0;
      subindo_q  <= 1'b1;
      timer_q    <= '0;
      erro_q     <= 1'b0;
      primeira_q <= 1'b1;
    end else begin
      estado_q   <= estado_d;
      posicao_q  <= posicao_d;
      subindo_q  <= subindo_d;
      timer_q    <= timer_d;
      erro_q     <= erro_d;
      primeira_q <= primeira_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    posicao_d  = posicao_q;
    subindo_d  = subindo_q;
    timer_d    = '0;
    erro_d     = erro_q;
    primeira_d = primeira_q;

    case (estado_q)
      INICIAL: begin
        if (ligar) begin
          estado_d   = PREPARA;
          erro_d     = 1'b0;
          primeira_d = 1'b1;
        end
      end
      PREPARA: estado_d = POSICIONA;
      POSICIONA: begin
        estado_d   = ESPERA_SERVO;
        primeira_d = 1'b0;
      end
      ESPERA_SERVO: begin
        if (timer_q == SETTLE_LAST) estado_d = DISPARA;
        else                        timer_d  = timer_q + TW'(1);
      end
      DISPARA: estado_d = ESPERA_MEDIDA;
      ESPERA_MEDIDA: begin
        // A result arriving on the last allowed cycle still counts as success.
        if (medida_pronto) begin
          estado_d = TRANSMITE;
        end else if (timer_q == TIMEOUT_LAST) begin
          estado_d = PROXIMA;
          erro_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      TRANSMITE: estado_d = ESPERA_TX;
      ESPERA_TX: begin
        if (tx_pronto) estado_d = PROXIMA;
      end
      PROXIMA: begin
        // Ping-pong: turn around at either end without revisiting the endpoint.
        if (subindo_q) begin
          if (posicao_q != POS_LAST) begin
            posicao_d = posicao_q + W_POS'(1);
          end else begin
            subindo_d = 1'b0;
            posicao_d = posicao_q - W_POS'(1);
          end
        end else begin
          if (posicao_q != '0) begin
            posicao_d = posicao_q - W_POS'(1);
          end else begin
            subindo_d = 1'b1;
            posicao_d = posicao_q + W_POS'(1);
          end
        end
        estado_d = ligar ? POSICIONA : INICIAL;
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_comb begin
    move_servo    = (estado_q == POSICIONA);
    inicio_medir  = (estado_q == DISPARA);
    inicia_tx     = (estado_q == TRANSMITE);
    fim_varredura = (estado_q == POSICIONA) && !primeira_q &&
                    ((posicao_q == '0) || (posicao_q == POS_LAST));
  end

  assign posicao      = posicao_q;
  assign erro_timeout = erro_q;
  assign db_estado    = estado_q;

endmodule
